// File: rtl/multi_cycle_cpu_pkg.sv
// cpu_pkg: opcode/funct constants, FSM state encoding and the seven-segment hex font
package cpu_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Micro-states; the numeric values are visible on the debug display
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_JMP    = 4'd11
  } state_t;

  // Hex digit to active-low segments {dp,g,f,e,d,c,b,a}, decimal point off
  function automatic logic [7:0] hex_font(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/multi_cycle_cpu_seg_scan.sv
// seg_scan: time-multiplexed 4-digit hex display driver with registered outputs
module seg_scan
  import cpu_pkg::*;
#(
  parameter int SCAN_BITS = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  output logic [7:0]  led_display,
  output logic [3:0]  led_pos
);

  logic [SCAN_BITS-1:0] cnt_reg;
  logic [1:0]           digit;
  logic [3:0]           nib;
  logic [3:0]           pos_next;

  // The top two counter bits pick the digit currently being lit
  assign digit = cnt_reg[SCAN_BITS-1 -: 2];
  assign nib   = value[{digit, 2'b00} +: 4];

  // Active-low one-hot enable: only the selected digit is driven low
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pos
      assign pos_next[gi] = (digit != 2'(gi));
    end
  endgenerate

  // Free-running refresh counter, independent of CPU stepping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + {{(SCAN_BITS-1){1'b0}}, 1'b1};
    end
  end

  // Register digit enable and segment pattern together so they never skew
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_pos     <= 4'b1110;
      led_display <= 8'hC0;
    end else begin
      led_pos     <= pos_next;
      led_display <= hex_font(nib);
    end
  end

endmodule

// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: single-stepped multi-cycle MIPS-subset CPU with hex debug display
module multi_cycle_cpu
  import cpu_pkg::*;
#(
  parameter string MEM_FILE  = "program.hex",
  parameter int    SCAN_BITS = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clkin_n,
  input  logic [2:0] SW,
  output logic [7:0] LED_display,
  output logic [3:0] LED_pos
);

  logic        sync1_reg, sync2_reg, prev_reg;
  logic        step;
  state_t      state_reg, state_next;
  logic [31:0] pc_reg, ir_reg, a_reg, b_reg, alu_out_reg, mdr_reg;
  logic [31:0] regs [0:31];
  logic [31:0] mem  [0:63];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext_imm;
  logic [5:0]  mem_idx;
  logic [31:0] mem_rdata;
  logic [31:0] rex_result;
  logic        rf_we, mem_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] disp_value;

  assign op       = ir_reg[31:26];
  assign rs       = ir_reg[25:21];
  assign rt       = ir_reg[20:16];
  assign rd       = ir_reg[15:11];
  assign funct    = ir_reg[5:0];
  assign sext_imm = {{16{ir_reg[15]}}, ir_reg[15:0]};

  // Two-flop synchronizer plus edge register for the asynchronous step input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= clkin_n;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  // One-cycle pulse on each synchronized falling edge
  assign step = prev_reg & ~sync2_reg;

  // Shared memory port: instruction fetch uses PC, data accesses use ALUOut
  assign mem_idx   = (state_reg == S_FETCH) ? pc_reg[7:2] : alu_out_reg[7:2];
  assign mem_rdata = mem[mem_idx];

  // Store port, only in MEMWR on a step
  always_ff @(posedge clk) begin
    if (step && mem_we) mem[alu_out_reg[7:2]] <= b_reg;
  end

  // Register file; $0 is never written so it stays zero after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (step && rf_we && (rf_waddr != 5'd0)) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // R-type ALU; an unrecognised funct yields zero but is still written back
  always_comb begin
    rex_result = '0;
    case (funct)
      FN_ADD:  rex_result = a_reg + b_reg;
      FN_SUB:  rex_result = a_reg - b_reg;
      FN_AND:  rex_result = a_reg & b_reg;
      FN_OR:   rex_result = a_reg | b_reg;
      FN_SLT:  rex_result = {31'b0, ($signed(a_reg) < $signed(b_reg))};
      default: rex_result = '0;
    endcase
  end

  // FSM state register, advancing only on step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else if (step) begin
      state_reg <= state_next;
    end
  end

  // Next-state and write-enable decode
  always_comb begin
    state_next = S_FETCH;
    rf_we      = 1'b0;
    rf_waddr   = rt;
    rf_wdata   = alu_out_reg;
    mem_we     = 1'b0;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_REX;
          OP_ADDI:      state_next = S_IEX;
          OP_BEQ:       state_next = S_BEQ;
          OP_J:         state_next = S_JMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = S_MEMWB;
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_reg;
      end
      S_MEMWR:  mem_we = 1'b1;
      S_REX:    state_next = S_RWB;
      S_RWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
      end
      S_IEX:    state_next = S_IWB;
      S_IWB:    rf_we = 1'b1;
      default:  state_next = S_FETCH;
    endcase
  end

  // Datapath registers, each updated in its own micro-state on a step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg      <= '0;
      ir_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      alu_out_reg <= '0;
      mdr_reg     <= '0;
    end else if (step) begin
      case (state_reg)
        S_FETCH: begin
          ir_reg <= mem_rdata;
          pc_reg <= pc_reg + 32'd4;
        end
        S_DECODE: begin
          a_reg       <= regs[rs];
          b_reg       <= regs[rt];
          alu_out_reg <= pc_reg + (sext_imm << 2);
        end
        S_MEMADR, S_IEX: alu_out_reg <= a_reg + sext_imm;
        S_MEMRD:         mdr_reg     <= mem_rdata;
        S_REX:           alu_out_reg <= rex_result;
        S_BEQ: begin
          if (a_reg == b_reg) pc_reg <= alu_out_reg;
        end
        S_JMP:           pc_reg <= {pc_reg[31:28], ir_reg[25:0], 2'b00};
        default: ;
      endcase
    end
  end

  // Debug display source select
  always_comb begin
    disp_value = '0;
    case (SW)
      3'b000:  disp_value = pc_reg[15:0];
      3'b001:  disp_value = ir_reg[31:16];
      3'b010:  disp_value = ir_reg[15:0];
      3'b011:  disp_value = alu_out_reg[15:0];
      3'b100:  disp_value = a_reg[15:0];
      3'b101:  disp_value = b_reg[15:0];
      3'b110:  disp_value = mdr_reg[15:0];
      default: disp_value = {12'b0, state_reg};
    endcase
  end

  seg_scan #(
    .SCAN_BITS(SCAN_BITS)
  ) u_seg_scan (
    .clk        (clk),
    .reset      (reset),
    .value      (disp_value),
    .led_display(LED_display),
    .led_pos    (LED_pos)
  );

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb_multi_cycle_cpu: random programs stepped through the CPU, checked via the display
module tb_multi_cycle_cpu;

  logic       clk = 1'b0;
  logic       reset;
  logic       clkin_n;
  logic [2:0] SW;
  logic [7:0] LED_display;
  logic [3:0] LED_pos;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_cycle_cpu #(
    .MEM_FILE (""),
    .SCAN_BITS(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clkin_n    (clkin_n),
    .SW         (SW),
    .LED_display(LED_display),
    .LED_pos    (LED_pos)
  );

  localparam logic [7:0] FONT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  localparam logic [3:0] POS_SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Architectural reference model
  logic [31:0] m_pc, m_ir, m_a, m_b, m_alu, m_mdr;
  logic [31:0] m_r   [32];
  logic [31:0] m_mem [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int s, input int t, input int d, input logic [5:0] f);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] o, input int s, input int t, input logic [15:0] imm);
    return {o, 5'(s), 5'(t), imm};
  endfunction

  function automatic logic [31:0] enc_j(input int word);
    return {6'h02, 26'(word)};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    int r1, r2, r3;
    logic [5:0] fn [6];
    logic [31:0] w;
    fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    k  = int'($urandom_range(0, 9));
    r1 = int'($urandom_range(0, 12));
    r2 = int'($urandom_range(0, 12));
    r3 = int'($urandom_range(1, 12));
    case (k)
      2, 3: w = enc_r(r1, r2, r3, fn[$urandom_range(0, 5)]);
      4:    w = enc_i(6'h23, 0, r3, 16'(128 + 4 * $urandom_range(0, 31)));
      5:    w = enc_i(6'h2B, 0, r2, 16'(128 + 4 * $urandom_range(0, 31)));
      6:    w = enc_i(6'h04, r1, r2, 16'($urandom_range(0, 6) - 3));
      7:    w = enc_j(int'($urandom_range(11, 30)));
      8:    w = 32'hFC00_0000 | ($urandom() & 32'h03FF_FFFF);
      default: w = enc_i(6'h08, r1, r3, 16'($urandom()));
    endcase
    return w;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_alu = 0; m_mdr = 0;
    for (int i = 0; i < 32; i++) m_r[i] = 0;
  endtask

  // Executes one whole instruction; returns its step count and its last micro-state
  task automatic model_exec(output int nsteps, output int last_state);
    logic [31:0] se, res;
    logic [5:0]  o, f;
    int s, t, d;
    m_ir = m_mem[m_pc[7:2]];
    m_pc = m_pc + 4;
    o  = m_ir[31:26];
    f  = m_ir[5:0];
    s  = int'(m_ir[25:21]);
    t  = int'(m_ir[20:16]);
    d  = int'(m_ir[15:11]);
    se = {{16{m_ir[15]}}, m_ir[15:0]};
    m_a   = m_r[s];
    m_b   = m_r[t];
    m_alu = m_pc + se * 4;
    case (o)
      6'h23: begin
        m_alu = m_a + se;
        m_mdr = m_mem[m_alu[7:2]];
        if (t != 0) m_r[t] = m_mdr;
        nsteps = 5; last_state = 4;
      end
      6'h2B: begin
        m_alu = m_a + se;
        m_mem[m_alu[7:2]] = m_b;
        nsteps = 4; last_state = 5;
      end
      6'h00: begin
        if (f == 6'h20)      res = m_a + m_b;
        else if (f == 6'h22) res = m_a - m_b;
        else if (f == 6'h24) res = m_a & m_b;
        else if (f == 6'h25) res = m_a | m_b;
        else if (f == 6'h2A) res = ($signed(m_a) < $signed(m_b)) ? 32'd1 : 32'd0;
        else                 res = 0;
        m_alu = res;
        if (d != 0) m_r[d] = res;
        nsteps = 4; last_state = 7;
      end
      6'h08: begin
        m_alu = m_a + se;
        if (t != 0) m_r[t] = m_alu;
        nsteps = 4; last_state = 10;
      end
      6'h04: begin
        if (m_a == m_b) m_pc = m_alu;
        nsteps = 3; last_state = 8;
      end
      6'h02: begin
        m_pc = {m_pc[31:28], m_ir[25:0], 2'b00};
        nsteps = 3; last_state = 11;
      end
      default: begin
        nsteps = 2; last_state = 1;
      end
    endcase
  endtask

  task automatic do_step(input int hold);
    @(negedge clk) clkin_n = 1'b0;
    repeat (hold) @(negedge clk);
    clkin_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Collect all four digits of the display for a given source and decode them
  task automatic check_disp(input string tag, input logic [2:0] sel, input logic [15:0] exp);
    logic [3:0]  seen;
    logic [15:0] val;
    int k, nib;
    seen = 0;
    val  = 0;
    @(negedge clk) SW = sel;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 40 && seen != 4'hF; c++) begin
      @(negedge clk);
      k = -1;
      for (int p = 0; p < 4; p++) if (LED_pos == POS_SEQ[p]) k = p;
      nib = -1;
      for (int n = 0; n < 16; n++) if (LED_display == FONT[n]) nib = n;
      if (k >= 0 && nib >= 0) begin
        val[k*4 +: 4] = 4'(nib);
        seen[k] = 1'b1;
      end
    end
    if (seen != 4'hF) check({tag, "_digits_seen"}, 32'(seen), 32'hF);
    else              check(tag, 32'(val), 32'(exp));
  endtask

  task automatic run_instr(input int idx, input int first_hold);
    int ns, last;
    logic [31:0] pc0;
    pc0 = m_pc;
    model_exec(ns, last);
    $display("instr %0d: pc=%h ir=%h steps=%0d", idx, pc0, m_ir, ns);
    for (int s = 0; s < ns - 1; s++) begin
      do_step((s == 0) ? first_hold : 6);
      if (s == 0 && first_hold > 6) check_disp("held_low_one_step", 3'b111, 16'd1);
    end
    check_disp("state_before_last", 3'b111, 16'(last));
    do_step(6);
    check_disp("state_fetch", 3'b111, 16'd0);
    check_disp("pc",      3'b000, m_pc[15:0]);
    check_disp("ir_hi",   3'b001, m_ir[31:16]);
    check_disp("ir_lo",   3'b010, m_ir[15:0]);
    check_disp("aluout",  3'b011, m_alu[15:0]);
    check_disp("a",       3'b100, m_a[15:0]);
    check_disp("b",       3'b101, m_b[15:0]);
    check_disp("mdr",     3'b110, m_mdr[15:0]);
  endtask

  initial begin
    int found;
    reset   = 1'b1;
    clkin_n = 1'b1;
    SW      = 3'b000;
    model_reset();

    // Directed prefix followed by random instructions and random data
    m_mem[0]  = enc_i(6'h08, 0, 1, 16'd5);
    m_mem[1]  = enc_i(6'h08, 0, 2, 16'd3);
    m_mem[2]  = enc_r(1, 2, 3, 6'h20);
    m_mem[3]  = enc_r(1, 2, 6, 6'h22);
    m_mem[4]  = enc_r(2, 1, 5, 6'h2A);
    m_mem[5]  = enc_i(6'h2B, 0, 3, 16'd128);
    m_mem[6]  = enc_i(6'h23, 0, 4, 16'd128);
    m_mem[7]  = enc_i(6'h04, 4, 3, 16'd1);
    m_mem[8]  = enc_i(6'h08, 0, 7, 16'd99);
    m_mem[9]  = enc_i(6'h04, 1, 2, 16'd1);
    m_mem[10] = 32'hFC00_0000;
    m_mem[11] = enc_r(1, 2, 8, 6'h24);
    m_mem[12] = enc_r(1, 2, 9, 6'h25);
    for (int i = 13; i < 31; i++) m_mem[i] = rand_instr();
    m_mem[31] = enc_j(11);
    for (int i = 32; i < 64; i++) m_mem[i] = $urandom();
    for (int i = 0; i < 64; i++) dut.mem[i] = m_mem[i];

    #50;
    check("reset_led_pos", 32'(LED_pos), 32'(4'b1110));
    @(negedge clk) reset = 1'b0;

    // Digit scan order: each digit held 2^(SCAN_BITS-2) cycles, showing zero
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      @(negedge clk);
      if (LED_pos == 4'b1101) found = 1;
    end
    check("scan_reached_digit1", 32'(found), 32'd1);
    check("scan_seg_digit1", 32'(LED_display), 32'hC0);
    for (int d = 2; d <= 4; d++) begin
      repeat (4) @(negedge clk);
      check("scan_pos", 32'(LED_pos), 32'(POS_SEQ[d % 4]));
      check("scan_seg", 32'(LED_display), 32'hC0);
    end
    check_disp("reset_pc", 3'b000, 16'h0000);
    check_disp("reset_state", 3'b111, 16'h0000);

    for (int n = 0; n < 70; n++) run_instr(n, (n == 20) ? 40 : 6);

    for (int i = 0; i < 32; i++) check("regfile", dut.regs[i], m_r[i]);
    for (int i = 0; i < 64; i++) check("memory", dut.mem[i], m_mem[i]);

    // Abort an lw in MEMRD with reset; memory survives, everything else clears
    @(negedge clk) reset = 1'b1;
    model_reset();
    m_mem[0] = enc_i(6'h23, 0, 7, 16'd140);
    dut.mem[0] = m_mem[0];
    repeat (3) @(negedge clk);
    reset = 1'b0;
    do_step(6);
    do_step(6);
    do_step(6);
    check_disp("in_memrd", 3'b111, 16'd3);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_pc", dut.pc_reg, 32'd0);
    check("async_reset_state", 32'(dut.state_reg), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_disp("post_reset_pc", 3'b000, 16'h0000);
    check_disp("post_reset_state", 3'b111, 16'h0000);
    check_disp("post_reset_mdr", 3'b110, 16'h0000);
    run_instr(100, 6);
    check("lw_after_reset_r7", dut.regs[7], m_r[7]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
